// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encoding, default sizes and the pattern-length width helper.
package seq_det_pkg;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_LEN_W = $clog2(DEF_MAX_LEN + 1);
  typedef enum logic [1:0] {UNPROG = 2'b00, HUNT = 2'b01, MATCH = 2'b10} state_t;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/seq_det_hist.sv
// seq_det_hist: history shift register, fill counter and masked compare producing complete.
module seq_det_hist import seq_det_pkg::*; #(
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        shift,
  input  logic                        x,
  input  logic [MAX_LEN-1:0]          pat,
  input  logic [len_w(MAX_LEN)-1:0]   len,
  input  logic                        ovl,
  output logic                        complete
);
  localparam int LW = len_w(MAX_LEN);
  logic [MAX_LEN-1:0] hist, hist_n, mask;
  logic [LW-1:0] fill, fill_n;
  // Compare against the post-shift history so a match is flagged on the sample that finishes it.
  always_comb begin
    hist_n = {hist[MAX_LEN-2:0], x};
    fill_n = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);
    mask = ~({MAX_LEN{1'b1}} << len);
    complete = shift && (fill_n >= len) && (((hist_n ^ pat) & mask) == '0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_n;
      fill <= (complete && !ovl) ? '0 : fill_n;
    end
  end
endmodule

// File: rtl/seq_det_prog.sv
// seq_det_prog: runtime-programmable Moore serial-pattern detector with saturating match count.
// Optional sticky `seen` output when SEQ_DET_STICKY_EN is defined.
module seq_det_prog import seq_det_pkg::*; #(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        x,
  input  logic                        x_vld,
  input  logic                        pat_wr,
  input  logic [MAX_LEN-1:0]          pat_in,
  input  logic [len_w(MAX_LEN)-1:0]   pat_len,
  input  logic                        ovl_mode,
  output logic                        y,
  output logic                        armed,
  output logic [CNT_W-1:0]            match_cnt
`ifdef SEQ_DET_STICKY_EN
  ,
  output logic                        seen
`endif
);
  localparam int LW = len_w(MAX_LEN);
  state_t state, state_n;
  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0] len_q;
  logic ovl_q, legal, shift, complete;
  assign legal = pat_wr && (pat_len != '0) && (pat_len <= LW'(MAX_LEN));
  // A legal load takes priority over a coincident sample, which is dropped.
  assign shift = x_vld && (state != UNPROG) && !legal;
  assign armed = state != UNPROG;
  assign y = state == MATCH;
  seq_det_hist #(.MAX_LEN(MAX_LEN)) u_hist (
    .clk(clk), .rst(rst), .clr(legal), .shift(shift), .x(x),
    .pat(pat_q), .len(len_q), .ovl(ovl_q), .complete(complete)
  );
  always_comb begin
    state_n = legal ? HUNT : (state == UNPROG) ? UNPROG : complete ? MATCH : HUNT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UNPROG;
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b0;
      match_cnt <= '0;
    end else begin
      state <= state_n;
      if (legal) begin
        pat_q <= pat_in;
        len_q <= pat_len;
        ovl_q <= ovl_mode;
        match_cnt <= '0;
      end else if (state_n == MATCH && match_cnt != '1) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end
`ifdef SEQ_DET_STICKY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seen <= 1'b0;
    else if (legal) seen <= 1'b0;
    else if (state_n == MATCH) seen <= 1'b1;
  end
`endif
endmodule
